// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall/flush requests from the datapath stages and
// the stall vector, flush pulse and multi-cycle status returned by pipe_ctrl.
// master = pipeline side (raises requests), slave = pipe_ctrl.
// Optional stall statistics output present when PIPE_CTRL_STAT_EN is defined.
interface pipe_ctrl_if #(
  parameter int CNT_W = 6
);
  logic              stallreq_from_id;
  logic              stallreq_from_ex;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic [31:0]       excepttype_i;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_busy;
  logic              mc_done;
`ifdef PIPE_CTRL_STAT_EN
  logic [31:0]       stall_cycles;
`endif

  modport master (
    output stallreq_from_id, stallreq_from_ex, ex_mc_start, ex_mc_cycles,
           excepttype_i,
    input  stall, flush, new_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_STAT_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, ex_mc_start, ex_mc_cycles,
           excepttype_i,
    output stall, flush, new_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_STAT_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline control: arbitrates ID/EX stall requests, sequences
// multi-cycle EX operations with an internal countdown, and raises a
// one-cycle flush with a redirect PC when MEM reports an exception.
// Optional feature macro: PIPE_CTRL_STAT_EN adds the stall_cycles counter.
// rst is asynchronous and active-low.
module pipe_ctrl #(
  parameter int          CNT_W   = 6,
  parameter logic [31:0] EXC_VEC = 32'h0000_0020
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave ctl
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MC_BUSY = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  // Stall vector bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_TO_ID = 6'b000111;
  localparam logic [5:0] STALL_TO_EX = 6'b001111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_busy_q, mc_busy_d;
  logic             flush_q, flush_d;
  logic             sc_done_q, sc_done_d;
  logic [31:0]      new_pc_q, new_pc_d;

  logic             exc_hit;
  logic             mc_long;
  logic             enter_flush;
  logic [5:0]       stall_c;

  // Countdown decrement that holds at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_dec_sat(input logic [CNT_W-1:0] v);
    return (v == CNT_ZERO) ? CNT_ZERO : v - CNT_ONE;
  endfunction

  assign exc_hit = |ctl.excepttype_i;
  // Occupancy of 0 or 1 cycle needs no sequencing: it behaves as a plain op.
  assign mc_long = (ctl.ex_mc_cycles > CNT_ONE);

  // Stall arbitration, highest priority first; combinational so every stage
  // register sees it in the same cycle the request is raised.
  always_comb begin
    stall_c = STALL_NONE;
    if (!rst) begin
      stall_c = STALL_NONE;
    end else if ((state_q == S_FLUSH) || exc_hit) begin
      stall_c = STALL_NONE;
    end else if ((state_q == S_MC_BUSY) && (cnt_q != CNT_ZERO)) begin
      stall_c = STALL_TO_EX;
    end else if ((state_q == S_IDLE) && ctl.ex_mc_start && mc_long) begin
      stall_c = STALL_TO_EX;
    end else if (ctl.stallreq_from_ex) begin
      stall_c = STALL_TO_EX;
    end else if (ctl.stallreq_from_id) begin
      stall_c = STALL_TO_ID;
    end
  end

  // Next-state and registered-output logic for the control FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mc_busy_d   = mc_busy_q;
    flush_d     = 1'b0;
    new_pc_d    = new_pc_q;
    sc_done_d   = 1'b0;
    enter_flush = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exc_hit) begin
          // Exception wins over a simultaneous multi-cycle start.
          state_d     = S_FLUSH;
          flush_d     = 1'b1;
          new_pc_d    = EXC_VEC;
          enter_flush = 1'b1;
        end else if (ctl.ex_mc_start) begin
          if (mc_long) begin
            // The start cycle itself is the first of ex_mc_cycles, and the
            // final busy cycle is spent at count zero, hence the minus two.
            state_d   = S_MC_BUSY;
            cnt_d     = ctl.ex_mc_cycles - CNT_TWO;
            mc_busy_d = 1'b1;
          end else begin
            sc_done_d = 1'b1;
          end
        end
      end
      S_MC_BUSY: begin
        if (exc_hit) begin
          // Abort: drop the operation without reporting completion.
          state_d     = S_FLUSH;
          flush_d     = 1'b1;
          new_pc_d    = EXC_VEC;
          cnt_d       = CNT_ZERO;
          mc_busy_d   = 1'b0;
          enter_flush = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
          state_d   = S_IDLE;
          mc_busy_d = 1'b0;
        end else begin
          // New ex_mc_start requests are ignored while counting down.
          cnt_d = cnt_dec_sat(cnt_q);
        end
      end
      S_FLUSH: begin
        // A still-present exception was already handled by this flush.
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = CNT_ZERO;
        mc_busy_d = 1'b0;
      end
    endcase
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      mc_busy_q <= 1'b0;
      flush_q   <= 1'b0;
      sc_done_q <= 1'b0;
      new_pc_q  <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mc_busy_q <= mc_busy_d;
      flush_q   <= flush_d;
      sc_done_q <= sc_done_d;
      new_pc_q  <= new_pc_d;
    end
  end

  assign ctl.stall   = stall_c;
  assign ctl.flush   = flush_q;
  assign ctl.new_pc  = new_pc_q;
  assign ctl.mc_busy = mc_busy_q;
  // Long ops finish on their last busy cycle; short ops report a cycle later.
  assign ctl.mc_done = ((state_q == S_MC_BUSY) && (cnt_q == CNT_ZERO)) || sc_done_q;

`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Statistics increment that sticks at all-ones.
  function automatic logic [31:0] stat_inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count cycles with the ID stage held; cleared on the edge that starts a flush.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (enter_flush) begin
      stall_cycles_d = 32'h0000_0000;
    end else if (stall_c[2]) begin
      stall_cycles_d = stat_inc_sat(stall_cycles_q);
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'h0000_0000;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ctl.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge of the same cycle.
// obs packs {stall[5:0], flush, mc_busy, mc_done}.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [8:0] obs;

  pipe_ctrl_if #(.CNT_W(6)) bus ();

  pipe_ctrl #(.CNT_W(6), .EXC_VEC(32'h0000_0020)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  assign obs = {bus.stall, bus.flush, bus.mc_busy, bus.mc_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stallreq_from_id = 1'b0;
    bus.stallreq_from_ex = 1'b0;
    bus.ex_mc_start      = 1'b0;
    bus.ex_mc_cycles     = 6'd0;
    bus.excepttype_i     = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.stallreq_from_id = 1'b1;
    bus.stallreq_from_ex = 1'b1;
    bus.ex_mc_start      = 1'b1;
    bus.ex_mc_cycles     = 6'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_hold_c%0d obs=%b exp=%b", c, obs, 9'b0);
      end
      n_chk++;
      if (bus.new_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_new_pc_c%0d got=%h exp=%h", c, bus.new_pc, 32'h0);
      end
      next_cycle();
    end
    rst = 1'b1;
    idle_inputs();
    bus.stallreq_from_id = 1'b1;
    @(negedge clk);
    n_chk++;
    if (obs !== 9'b000111000) begin
      n_fail++;
      $display("FAIL reset_release obs=%b exp=%b", obs, 9'b000111000);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_idle obs=%b exp=%b", obs, 9'b0);
    end
    next_cycle();
  endtask

  task automatic test_id_ex_stall();
    logic [8:0] exp_t [4];
    exp_t = '{9'b000111000, 9'b001111000, 9'b001111000, 9'b000000000};
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0 || c == 1) bus.stallreq_from_id = 1'b1;
      if (c == 1 || c == 2) bus.stallreq_from_ex = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs !== exp_t[c]) begin
        n_fail++;
        $display("FAIL id_ex_stall_c%0d obs=%b exp=%b", c, obs, exp_t[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_multicycle();
    logic [8:0] exp_t [6];
    exp_t = '{9'b001111000, 9'b001111010, 9'b001111010,
              9'b001111010, 9'b000000011, 9'b000000000};
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0) begin
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = 6'd5;
      end
      if (c == 2) begin
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = 6'd3;
      end
      @(negedge clk);
      n_chk++;
      if (obs !== exp_t[c]) begin
        n_fail++;
        $display("FAIL multicycle5_c%0d obs=%b exp=%b", c, obs, exp_t[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_cycle();
    logic [8:0] exp_t [3];
    logic [5:0] cyc [2];
    exp_t = '{9'b000000000, 9'b000000001, 9'b000000000};
    cyc   = '{6'd1, 6'd0};
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        idle_inputs();
        if (c == 0) begin
          bus.ex_mc_start  = 1'b1;
          bus.ex_mc_cycles = cyc[k];
        end
        @(negedge clk);
        n_chk++;
        if (obs !== exp_t[c]) begin
          n_fail++;
          $display("FAIL single_cycle_n%0d_c%0d obs=%b exp=%b", cyc[k], c, obs, exp_t[c]);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_exception_abort();
    logic [8:0] exp_t [10];
    exp_t = '{9'b001111000, 9'b001111010, 9'b001111010, 9'b000000010,
              9'b000000100, 9'b000111000, 9'b000000000, 9'b000000000,
              9'b000000000, 9'b000000000};
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c == 0) begin
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = 6'd36;
      end
      if (c == 3) bus.excepttype_i = 32'h0000_000e;
      if (c == 5) bus.stallreq_from_id = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs !== exp_t[c]) begin
        n_fail++;
        $display("FAIL exc_abort_c%0d obs=%b exp=%b", c, obs, exp_t[c]);
      end
      if (c == 4) begin
        n_chk++;
        if (bus.new_pc !== 32'h0000_0020) begin
          n_fail++;
          $display("FAIL exc_abort_new_pc got=%h exp=%h", bus.new_pc, 32'h0000_0020);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_exc_in_flush();
    logic [8:0] exp_t [4];
    exp_t = '{9'b000000000, 9'b000000100, 9'b000000000, 9'b000000000};
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin
        bus.excepttype_i     = 32'h0000_0001;
        bus.stallreq_from_id = 1'b1;
      end
      if (c == 1) bus.excepttype_i = 32'h0000_0001;
      @(negedge clk);
      n_chk++;
      if (obs !== exp_t[c]) begin
        n_fail++;
        $display("FAIL exc_in_flush_c%0d obs=%b exp=%b", c, obs, exp_t[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_start_vs_exception();
    logic [8:0] exp_t [6];
    exp_t = '{9'b000000000, 9'b000000100, 9'b000000000,
              9'b000000000, 9'b000000100, 9'b000000000};
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0 || c == 3) begin
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = (c == 0) ? 6'd5 : 6'd1;
        bus.excepttype_i = 32'h0000_0004;
      end
      @(negedge clk);
      n_chk++;
      if (obs !== exp_t[c]) begin
        n_fail++;
        $display("FAIL start_vs_exc_c%0d obs=%b exp=%b", c, obs, exp_t[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    bus.ex_mc_start  = 1'b1;
    bus.ex_mc_cycles = 6'd10;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (obs !== 9'b001111010) begin
      n_fail++;
      $display("FAIL rst_mid_busy obs=%b exp=%b", obs, 9'b001111010);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    n_chk++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async obs=%b exp=%b", obs, 9'b0);
    end
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== 9'b0) begin
        n_fail++;
        $display("FAIL rst_mid_after_c%0d obs=%b exp=%b", c, obs, 9'b0);
      end
      next_cycle();
    end
  endtask

`ifdef PIPE_CTRL_STAT_EN
  task automatic test_stat();
    idle_inputs();
    bus.excepttype_i = 32'h0000_0002;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (bus.stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL stat_clear0 got=%0d exp=%0d", bus.stall_cycles, 0);
    end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      bus.stallreq_from_id = 1'b1;
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c == 0) begin
        bus.ex_mc_start  = 1'b1;
        bus.ex_mc_cycles = 6'd5;
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (bus.stall_cycles !== 32'd7) begin
      n_fail++;
      $display("FAIL stat_count got=%0d exp=%0d", bus.stall_cycles, 7);
    end
    next_cycle();
    bus.excepttype_i = 32'h0000_0008;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (bus.stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL stat_flush_clear got=%0d exp=%0d", bus.stall_cycles, 0);
    end
    next_cycle();
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle_inputs();
    next_cycle();
    test_reset();
    test_id_ex_stall();
    test_multicycle();
    test_single_cycle();
    test_exception_abort();
    test_exc_in_flush();
    test_start_vs_exception();
    test_reset_mid_op();
`ifdef PIPE_CTRL_STAT_EN
    test_stat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit: the producer of the 6-bit stall vector and the flush signal consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates stall requests from ID and EX.
- Sequences multi-cycle EX operations (div, madd/msub) with an internal countdown so EX does not hold its own stall request.
- Raises a one-cycle flush with a redirect PC on exceptions.

Parameters:
- CNT_W, 6, width of the multi-cycle countdown and of ex_mc_cycles.
- EXC_VEC, 32'h0000_0020, redirect PC driven on new_pc during flush.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stallreq_from_id  in  1  ID-stage stall request (load-use hazard).
- stallreq_from_ex  in  1  EX-stage single-cycle stall request.
- ex_mc_start  in  1  EX starts a multi-cycle operation (one-cycle pulse).
- ex_mc_cycles  in  CNT_W  total EX occupancy in cycles for that operation.
- excepttype_i  in  32  exception type from MEM; nonzero means take exception.
- stall  out  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold stage.
- flush  out  1  clear all pipeline registers (registered pulse).
- new_pc  out  32  redirect target, valid while flush=1.
- mc_busy  out  1  multi-cycle operation in progress.
- mc_done  out  1  one-cycle pulse on the final busy cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, stall=0, flush=0, new_pc=0, mc_busy=0, mc_done=0.
- States: IDLE, MC_BUSY, FLUSH.
- stall is combinational from current state and inputs, so it is seen in the same cycle by the stage registers.
- Stall priority, highest first:
  - state FLUSH or excepttype_i!=0 → stall=000000.
  - state MC_BUSY and counter!=0 → 001111.
  - ex_mc_start in IDLE with cycles>1 → 001111.
  - stallreq_from_ex → 001111.
  - stallreq_from_id → 000111.
  - otherwise → 000000.
- IDLE:
  - excepttype_i!=0 → FLUSH; flush<=1, new_pc<=EXC_VEC.
  - else ex_mc_start with ex_mc_cycles>1 → MC_BUSY; counter<=ex_mc_cycles-2; mc_busy<=1.
  - ex_mc_cycles of 0 or 1 is treated as single-cycle: no state change, mc_done<=1 next cycle.
- MC_BUSY:
  - Each cycle: counter decrements.
  - When counter==0 on a clock edge: counter stays 0, → IDLE, mc_busy<=0, mc_done pulses on that last busy cycle (combinationally qualified, mc_done = state==MC_BUSY && counter==0).
  - The stall on the final cycle is released, so total EX occupancy equals ex_mc_cycles.
  - ex_mc_start while in MC_BUSY is ignored.
- FLUSH:
  - Exactly one cycle with flush=1, then → IDLE; flush<=0.
  - excepttype_i!=0 during MC_BUSY aborts the operation: → FLUSH, counter<=0, mc_busy<=0, no mc_done.
  - excepttype_i!=0 while in FLUSH is ignored; it has already been handled.
- Simultaneous ex_mc_start and excepttype_i: exception wins and the operation is discarded.
- Simultaneous stallreq_from_id and stallreq_from_ex: 001111 (EX dominates).
- Reset asserted mid-operation: immediate return to reset values; no mc_done.
- Counter arithmetic is unsigned CNT_W bits; the decrement never wraps below 0.

Optional Feature:
- Macro PIPE_CTRL_STAT_EN.
- When defined, add output stall_cycles (32 bits): a counter incremented every cycle with stall[2]==1, saturating at 32'hFFFF_FFFF, cleared by reset and by flush.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all requests active → stall=000000, flush=0, mc_busy=0; release → IDLE, stall follows the inputs.
- stallreq_from_id=1 for 2 cycles → stall=000111 for exactly those cycles; add stallreq_from_ex=1 in cycle 2 → 001111 in cycle 2.
- ex_mc_start with ex_mc_cycles=5:
  - stall=001111 for cycles 1–4 and 000000 in cycle 5.
  - mc_busy=1 for cycles 2–5.
  - mc_done=1 only in cycle 5.
- ex_mc_cycles=1 and ex_mc_cycles=0 → no stall, mc_busy stays 0, mc_done pulses the next cycle.
- excepttype_i=32'h0000_000e during the third busy cycle of a 36-cycle operation → next cycle flush=1, new_pc=EXC_VEC, stall=000000, mc_busy=0, mc_done never asserts; the following cycle flush=0, state IDLE.
- With PIPE_CTRL_STAT_EN: 3 cycles of stallreq_from_id plus a 5-cycle multi-cycle op → stall_cycles=7; then an exception → stall_cycles=0.
